// File: rtl/pipe_pkg.sv
// Shared types for the pipeline skid register.
// The state encoding doubles as the occupancy count, so the state value can
// drive the occupancy port directly.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } state_e;

endpackage : pipe_pkg

// File: rtl/pipe_skid_reg_en_reg.sv
// Load-enable register with asynchronous active-low reset to a parameterised value.
// The pipeline stage uses one instance for the head entry and one for the skid entry.
module en_reg #(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    // Capture d_i when enabled; otherwise hold.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= RESET_VAL;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule : en_reg

// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline stage register with valid/ready handshake on both sides.
// in_ready comes from registered state only (never from out_ready), so the
// upstream ready path is fully registered. flush squashes both entries.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    state_e           state_q, state_d;
    logic             in_xfer, out_xfer;
    logic             main_en, skid_en;
    logic [WIDTH-1:0] main_d, skid_d;
    logic [WIDTH-1:0] main_q, skid_q;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // State register: asynchronously cleared to EMPTY.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and register steering; flush overrides every transition.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        main_en = 1'b0;
        main_d  = in_data;
        skid_en = 1'b0;
        skid_d  = in_data;
        if (flush) begin
            state_d = EMPTY;
            main_en = 1'b1;
            main_d  = RESET_VAL;
            skid_en = 1'b1;
            skid_d  = RESET_VAL;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d = ONE;
                        main_en = 1'b1;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_en = 1'b1;
                    end else if (in_xfer) begin
                        state_d = TWO;
                        skid_en = 1'b1;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    // Head drains; the skid entry moves up into the head.
                    if (out_xfer) begin
                        state_d = ONE;
                        main_en = 1'b1;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Handshake outputs derived from registered state and reset only.
    always_comb begin
        out_valid = (state_q != EMPTY);
        in_ready  = reset & (state_q != TWO);
        occupancy = state_q;
    end

    en_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
        .clk   (clk),
        .rst_n (reset),
        .en_i  (main_en),
        .d_i   (main_d),
        .q_o   (main_q)
    );

    en_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
        .clk   (clk),
        .rst_n (reset),
        .en_i  (skid_en),
        .d_i   (skid_d),
        .q_o   (skid_q)
    );

    assign out_data = main_q;

endmodule : pipe_skid_reg

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: a 32-bit instance driven through reset,
// streaming, backpressure, flush and async reset, with a FIFO scoreboard,
// plus an 8-bit instance with a non-zero reset value.
module tb_pipe_skid_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  occupancy;

    logic        flush8;
    logic        in_valid8;
    logic        in_ready8;
    logic [7:0]  in_data8;
    logic        out_valid8;
    logic        out_ready8;
    logic [7:0]  out_data8;
    logic [1:0]  occupancy8;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    pipe_skid_reg #(.WIDTH(32), .RESET_VAL(32'd0)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    pipe_skid_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush8),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .in_data   (in_data8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .out_data  (out_data8),
        .occupancy (occupancy8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard update for the coming edge; inputs are stable from posedge+1
    // through the next posedge, so the negedge view equals the edge view.
    task automatic monitor();
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow_out_valid", 32'(out_valid), 32'd0);
            end else begin
                check("sb_out_data", out_data, sb_q.pop_front());
            end
        end
        if (flush) begin
            sb_q.delete();
        end else if (in_valid && in_ready) begin
            sb_q.push_back(in_data);
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b1;
        in_data    = 32'd2;
        out_ready  = 1'b0;
        flush8     = 1'b0;
        in_valid8  = 1'b0;
        in_data8   = 8'h00;
        out_ready8 = 1'b0;

        // Reset held with in_valid asserted.
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        step();
        step();
        check("rst_out_valid2", 32'(out_valid), 32'd0);
        check("rst_out_data",   out_data,       32'd0);
        check("rst_in_ready2",  32'(in_ready),  32'd0);
        check("rst_occupancy",  32'(occupancy), 32'd0);
        check("rst8_out_data",  32'(out_data8), 32'h0000_00A5);

        // Release reset; 2 accepted at the next edge and visible after it.
        reset = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);
        in_valid8  = 1'b1;
        in_data8   = 8'hFF;
        out_ready8 = 1'b1;
        step();
        check("first_out_valid", 32'(out_valid), 32'd1);
        check("first_out_data",  out_data,       32'd2);
        check("first_occupancy", 32'(occupancy), 32'd1);
        check("p8_out_data",     32'(out_data8), 32'h0000_00FF);
        check("p8_out_valid",    32'(out_valid8), 32'd1);
        in_valid8 = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("drain_occupancy", 32'(occupancy), 32'd0);

        // Full-throughput stream.
        out_ready = 1'b1;
        for (int i = 5; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i);
            step();
            check("stream_occupancy", 32'(occupancy), 32'd1);
            check("stream_in_ready",  32'(in_ready),  32'd1);
            check("stream_out_data",  out_data,       32'(i));
        end
        in_valid = 1'b0;
        step();
        check("stream_end_occ", 32'(occupancy), 32'd0);

        // Backpressure fills the skid entry.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'd10;
        step();
        in_data = 32'd11;
        step();
        in_valid = 1'b0;
        check("bp_occupancy", 32'(occupancy), 32'd2);
        check("bp_in_ready",  32'(in_ready),  32'd0);
        check("bp_out_data",  out_data,       32'd10);
        out_ready = 1'b1;
        #1;
        check("bp_ready_no_comb", 32'(in_ready), 32'd0);
        step();
        check("bp_occ_after1",   32'(occupancy), 32'd1);
        check("bp_ready_after1", 32'(in_ready),  32'd1);
        check("bp_data_after1",  out_data,       32'd11);
        step();
        check("bp_occ_after2", 32'(occupancy), 32'd0);

        // Flush while holding two entries, with a same-cycle input.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'd20;
        step();
        in_data = 32'd21;
        step();
        check("fl_full_occ", 32'(occupancy), 32'd2);
        flush    = 1'b1;
        in_data  = 32'd22;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_occupancy", 32'(occupancy), 32'd0);
        check("fl_out_valid", 32'(out_valid), 32'd0);
        check("fl_out_data",  out_data,       32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("fl_stays_empty", 32'(out_valid), 32'd0);
            check("fl_no_22",       out_data,       32'd0);
        end

        // Asynchronous reset between edges while holding 30.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'd30;
        step();
        in_valid = 1'b0;
        check("ar_occupancy", 32'(occupancy), 32'd1);
        check("ar_out_data",  out_data,       32'd30);
        #2;
        reset = 1'b0;
        #1;
        check("ar_out_valid_async", 32'(out_valid), 32'd0);
        check("ar_out_data_async",  out_data,       32'd0);
        check("ar_occ_async",       32'(occupancy), 32'd0);
        sb_q.delete();
        step();
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'd31;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("ar_after_data",  out_data,        32'd31);
        check("ar_after_valid", 32'(out_valid),  32'd1);
        step();
        check("ar_drained", 32'(occupancy), 32'd0);
        check("sb_empty",   32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pipe_skid_reg

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised pipeline stage register for the MIPS datapath; the successor to the plain 32-bit always-load register.
- Adds the following over the plain register:
  - generic width and reset value;
  - valid/ready handshake on both sides;
  - a second (skid) entry, so upstream ready is fully registered with no combinational path from out_ready;
  - synchronous flush for branch/exception squash.
- Sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- WIDTH, 32, payload width in bits (>=1).
- RESET_VAL, 0, value driven on out_data after reset or flush.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset: asserted when 0. Assertion takes effect immediately; release is synchronous to clk.
- flush  input  1  synchronous squash of all held entries.
- in_valid  input  1  upstream holds valid data.
- in_ready  output  1  block can accept this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  WIDTH  payload of the oldest held entry.
- occupancy  output  2  entries held: 0, 1 or 2.

Behaviour:
- Transfers: an input transfer occurs when in_valid & in_ready at a clk rising edge. An output transfer occurs when out_valid & out_ready at a clk rising edge.
- Storage: main register (always the head) and skid register. State is EMPTY, ONE or TWO; occupancy = 0/1/2 respectively.
- out_valid = (state != EMPTY). out_data = main register.
- in_ready = reset & (state != TWO). It depends only on state and reset, never on out_ready or in_valid.
- Latency: 1 cycle. Data accepted at edge N appears on out_data/out_valid after edge N when the block was EMPTY.
- Transitions (flush low):
  - EMPTY + in transfer -> ONE; main <= in_data.
  - ONE + in + out transfers -> ONE; main <= in_data.
  - ONE + in only -> TWO; skid <= in_data.
  - ONE + out only -> EMPTY; main holds its last value.
  - TWO + out transfer -> ONE; main <= skid. No input accepted, because in_ready = 0.
  - No transfer -> state and both registers hold.
- Ordering: strict FIFO. No entry is dropped or duplicated.
- Flush high at an edge:
  - next state EMPTY;
  - main and skid <= RESET_VAL;
  - any same-cycle input transfer is discarded;
  - a same-cycle output transfer still counts as consumed downstream;
  - flush has priority over every transition.
- Reset low:
  - state EMPTY immediately (asynchronous);
  - main and skid = RESET_VAL;
  - out_valid = 0, occupancy = 0, in_ready = 0.
  - After reset rises, in_ready = 1 from the next evaluation; the first transfer is possible at the first following edge.
- Reset mid-operation: held entries are lost. No partial update is visible.
- out_data while out_valid = 0 holds the last value, or RESET_VAL after reset/flush. Downstream must ignore it.
- in_data is sampled only on an input transfer. X on in_data while in_valid = 0 must not propagate.

Decomposition:
- Shared package pipe_pkg holds the state enum: EMPTY = 2'b00, ONE = 2'b01, TWO = 2'b10.
- Occupancy is encoded identically to the state, so occupancy = state.
- One sub-module: en_reg, a WIDTH-parametrised load-enable register with asynchronous active-low reset to RESET_VAL. It is instantiated twice, as main and skid.
- The state machine and steering mux stay in pipe_skid_reg.

Test Plan:
- Reset sequencing: reset = 0 for 2 cycles with in_valid = 1, in_data = 32'd2 -> out_valid = 0, out_data = 0, in_ready = 0, occupancy = 0. Release reset -> in_ready = 1, and 2 appears on out_data one edge later.
- Full-throughput stream: out_ready held 1, send 5, 6, 7, 8 on consecutive cycles -> out_data = 5, 6, 7, 8 on consecutive cycles, occupancy stays 1, in_ready never drops.
- Backpressure/skid: out_ready = 0, send 10 then 11 -> occupancy = 2, in_ready = 0, out_data = 10. Raise out_ready -> 10 then 11 delivered in order, and in_ready = 1 after the first output transfer.
- Flush: block holds 20 and 21 (TWO). Pulse flush together with in_valid = 1, in_data = 22 -> next cycle occupancy = 0, out_valid = 0, out_data = RESET_VAL, and 22 never appears on out_data.
- Asynchronous reset mid-operation: block holds 30 (ONE). Drop reset between edges -> out_valid falls without waiting for a clock edge, out_data = 0. After release, sending 31 outputs 31.
- Parameter check: WIDTH = 8, RESET_VAL = 8'hA5. Reset -> out_data = 8'hA5. Send 8'hFF with out_ready = 1 -> out_data = 8'hFF one edge later.
